tlb_page_walker: RTL and testbench

Hardware page-table walker sitting directly downstream of the TLB miss path. On a TLB miss it accepts the faulting virtual address, performs a two-level table walk through a simple request/acknowledge memory port, and returns either a fill (VPN→PPN pair plus `unfault` pulse) for the TLB's fault-refill input or a page-fault indication to the core. One walk in flight at a time.

---
 rtl/tlb_page_walker.sv | 184 ++++++++++++++++++
 tb/tb_tlb_page_walker.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_page_walker.sv
// Two-level hardware page-table walker feeding TLB refills or page faults.
// Optional WALKER_SUPERPAGE_EN accepts level-1 leaves as 4 MiB superpages.
module tlb_page_walker #(
  parameter  int unsigned TIMEOUT   = 255,
  localparam int unsigned BIT_COUNT = 32,
  localparam int unsigned PN_W      = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_COUNT-1:0] ptbr,
  input  logic                 flush,
  input  logic                 miss_valid,
  input  logic [BIT_COUNT-1:0] miss_va,
  output logic                 miss_ready,
  output logic                 mem_req,
  output logic [BIT_COUNT-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [BIT_COUNT-1:0] mem_rdata,
  output logic                 fill_valid,
  output logic [PN_W-1:0]      fill_vpn,
  output logic [PN_W-1:0]      fill_ppn,
  output logic                 unfault,
  output logic                 page_fault,
  output logic [1:0]           fault_cause
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CAUSE_INVALID = 2'b01;
  localparam logic [1:0] CAUSE_LEAF    = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {IDLE, L1, L0, RESP, FAULT} state_e;

  state_e                 state_q, state_d;
  logic [PN_W-1:0]        vpn_q, vpn_d;
  logic [PN_W-1:0]        base_q, base_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   drop_q, drop_d;
  logic                   miss_ready_q, miss_ready_d;
  logic                   mem_req_q, mem_req_d;
  logic [BIT_COUNT-1:0]   mem_addr_q, mem_addr_d;
  logic                   fill_valid_q, fill_valid_d;
  logic [PN_W-1:0]        fill_vpn_q, fill_vpn_d;
  logic [PN_W-1:0]        fill_ppn_q, fill_ppn_d;
  logic                   unfault_q, unfault_d;
  logic                   page_fault_q, page_fault_d;
  logic [1:0]             fault_cause_q, fault_cause_d;
  logic                   timed_out;
  logic                   unused_bits;

  assign timed_out   = (cnt_q == CW'(TIMEOUT - 1));
  assign unused_bits = ^{ptbr[11:0], miss_va[11:0], mem_rdata[11:2]};

  // Outputs are registered from the next-state decode so each pulse lines up
  // with the cycle the FSM sits in RESP/FAULT. A flush sampled on the same edge
  // as the final ack already folds into drop_d and suppresses that pulse.
  always_comb begin
    state_d       = state_q;
    vpn_d         = vpn_q;
    base_d        = base_q;
    cnt_d         = cnt_q;
    drop_d        = drop_q;
    mem_addr_d    = mem_addr_q;
    fill_vpn_d    = fill_vpn_q;
    fill_ppn_d    = fill_ppn_q;
    fault_cause_d = fault_cause_q;

    case (state_q)
      IDLE: begin
        if (miss_valid) begin
          vpn_d   = miss_va[31:12];
          base_d  = ptbr[31:12];
          cnt_d   = '0;
          drop_d  = 1'b0;
          state_d = L1;
        end
      end
      L1, L0: begin
        drop_d = drop_q | flush;
        if (mem_ack || timed_out) begin
          if (drop_d) begin
            state_d = IDLE;
            drop_d  = 1'b0;
          end else if (!mem_ack) begin
            state_d       = FAULT;
            fault_cause_d = CAUSE_TIMEOUT;
          end else if (!mem_rdata[0]) begin
            state_d       = FAULT;
            fault_cause_d = CAUSE_INVALID;
          end else if (!mem_rdata[1]) begin
            if (state_q == L1) begin
              state_d = L0;
              base_d  = mem_rdata[31:12];
              cnt_d   = '0;
            end else begin
              state_d       = FAULT;
              fault_cause_d = CAUSE_LEAF;
            end
          end else if (state_q == L0) begin
            state_d    = RESP;
            fill_ppn_d = mem_rdata[31:12];
          end else begin
`ifdef WALKER_SUPERPAGE_EN
            if (mem_rdata[21:12] != '0) begin
              state_d       = FAULT;
              fault_cause_d = CAUSE_LEAF;
            end else begin
              state_d    = RESP;
              fill_ppn_d = {mem_rdata[31:22], vpn_q[9:0]};
            end
`else
            state_d       = FAULT;
            fault_cause_d = CAUSE_LEAF;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP, FAULT: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == RESP) fill_vpn_d = vpn_q;

    if (state_d == L1)      mem_addr_d = {base_d, vpn_d[19:10], 2'b00};
    else if (state_d == L0) mem_addr_d = {base_d, vpn_d[9:0], 2'b00};

    miss_ready_d = (state_d == IDLE);
    mem_req_d    = (state_d == L1) || (state_d == L0);
    fill_valid_d = (state_d == RESP);
    unfault_d    = (state_d == RESP);
    page_fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      vpn_q         <= '0;
      base_q        <= '0;
      cnt_q         <= '0;
      drop_q        <= 1'b0;
      miss_ready_q  <= 1'b1;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      fill_valid_q  <= 1'b0;
      fill_vpn_q    <= '0;
      fill_ppn_q    <= '0;
      unfault_q     <= 1'b0;
      page_fault_q  <= 1'b0;
      fault_cause_q <= '0;
    end else begin
      state_q       <= state_d;
      vpn_q         <= vpn_d;
      base_q        <= base_d;
      cnt_q         <= cnt_d;
      drop_q        <= drop_d;
      miss_ready_q  <= miss_ready_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      fill_valid_q  <= fill_valid_d;
      fill_vpn_q    <= fill_vpn_d;
      fill_ppn_q    <= fill_ppn_d;
      unfault_q     <= unfault_d;
      page_fault_q  <= page_fault_d;
      fault_cause_q <= fault_cause_d;
    end
  end

  assign miss_ready  = miss_ready_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign fill_valid  = fill_valid_q;
  assign fill_vpn    = fill_vpn_q;
  assign fill_ppn    = fill_ppn_q;
  assign unfault     = unfault_q;
  assign page_fault  = page_fault_q;
  assign fault_cause = fault_cause_q;

endmodule

// File: tb/tb_tlb_page_walker.sv
// Directed bench for tlb_page_walker: memory responder, scoreboard of expected
// fill/fault pulses, and cycle-exact checks of the walk timing.
module tb_tlb_page_walker;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ptbr;
  logic        flush;
  logic        miss_valid;
  logic [31:0] miss_va;
  logic        miss_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        fill_valid;
  logic [19:0] fill_vpn;
  logic [19:0] fill_ppn;
  logic        unfault;
  logic        page_fault;
  logic [1:0]  fault_cause;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        is_fill;
    logic [19:0] vpn;
    logic [19:0] ppn;
    logic [1:0]  cause;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];
  logic        ack_en     = 1'b1;
  logic [31:0] slow_addr  = 32'hFFFF_FFFF;
  int          slow_delay = 0;

  tlb_page_walker #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ptbr       (ptbr),
    .flush      (flush),
    .miss_valid (miss_valid),
    .miss_va    (miss_va),
    .miss_ready (miss_ready),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .fill_valid (fill_valid),
    .fill_vpn   (fill_vpn),
    .fill_ppn   (fill_ppn),
    .unfault    (unfault),
    .page_fault (page_fault),
    .fault_cause(fault_cause)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic push_fill(input logic [19:0] v, input logic [19:0] p);
    exp_t e;
    e.is_fill = 1'b1; e.vpn = v; e.ppn = p; e.cause = 2'b00;
    exp_q.push_back(e);
  endtask

  task automatic push_fault(input logic [1:0] c);
    exp_t e;
    e.is_fill = 1'b0; e.vpn = '0; e.ppn = '0; e.cause = c;
    exp_q.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, {miss_ready, mem_req, fill_valid, unfault, page_fault, fault_cause}, 32'b100_0000);
    check({tag, "_addr"}, mem_addr, 32'h0);
    check({tag, "_vpn"}, fill_vpn, 32'h0);
    check({tag, "_ppn"}, fill_ppn, 32'h0);
  endtask

  // Drive a one-cycle miss; returns in the first cycle after acceptance.
  task automatic start_miss(input logic [31:0] va);
    check("ready_before_miss", miss_ready, 1);
    miss_va    = va;
    miss_valid = 1'b1;
    @(negedge clk);
    miss_valid = 1'b0;
  endtask

  task automatic pulse_after(input string tag, input int n);
    repeat (n) @(negedge clk);
    check({tag, "_pulse"}, fill_valid | page_fault, 1);
    @(negedge clk);
    check({tag, "_ready"}, miss_ready, 1);
  endtask

  task automatic wait_pulse(input string tag, input int budget);
    int n = 0;
    while (!(fill_valid || page_fault) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_pulse_seen"}, fill_valid | page_fault, 1);
    @(negedge clk);
    check({tag, "_ready_after"}, miss_ready, 1);
  endtask

  // Memory responder: acks after a per-address delay, data from mem[].
  initial begin
    int wait_cnt;
    int dly;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req && ack_en) begin
        dly = (mem_addr == slow_addr) ? slow_delay : 0;
        if (wait_cnt >= dly) begin
          mem_ack   = 1'b1;
          mem_rdata = rd(mem_addr);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Scoreboard consumer: every pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && (fill_valid || page_fault || unfault)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {fill_valid, unfault, page_fault}, 0);
        end else begin
          e = exp_q.pop_front();
          if (e.is_fill) begin
            check("fill_valid", fill_valid, 1);
            check("unfault", unfault, 1);
            check("fill_vpn", fill_vpn, e.vpn);
            check("fill_ppn", fill_ppn, e.ppn);
          end else begin
            check("page_fault", page_fault, 1);
            check("fill_absent", {fill_valid, unfault}, 0);
            check("fault_cause", fault_cause, e.cause);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    ptbr       = '0;
    flush      = 1'b0;
    miss_valid = 1'b0;
    miss_va    = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;
    @(negedge clk);

    // Two-level walk, back-to-back acks; ptbr changes after accept are ignored.
    mem[32'h0001_0004] = 32'h0002_0001;
    mem[32'h0002_000C] = 32'h1234_5003;
    ptbr = 32'h0001_0000;
    push_fill(20'h00403, 20'h12345);
    start_miss(32'h0040_3ABC);
    ptbr = 32'hFFFF_0000;
    check("l1_req", mem_req, 1);
    check("l1_addr", mem_addr, 32'h0001_0004);
    check("busy", miss_ready, 0);
    @(negedge clk);
    check("l0_req", mem_req, 1);
    check("l0_addr", mem_addr, 32'h0002_000C);
    @(negedge clk);
    check("fill_t3", {fill_valid, unfault}, 2'b11);
    @(negedge clk);
    check("ready_t4", miss_ready, 1);
    check("fill_done", fill_valid, 0);
    ptbr = 32'h0001_0000;

    // Invalid level-1 PTE.
    mem[32'h0001_0004] = 32'h0;
    push_fault(2'b01);
    start_miss(32'h0040_3ABC);
    pulse_after("inv_l1", 1);

    // Level-1 leaf, aligned and misaligned superpage.
    mem[32'h0001_0004] = 32'h0C00_0003;
`ifdef WALKER_SUPERPAGE_EN
    push_fill(20'h00403, 20'h0C003);
`else
    push_fault(2'b10);
`endif
    start_miss(32'h0040_3ABC);
    pulse_after("super_ok", 1);
    mem[32'h0001_0004] = 32'h0C00_1003;
    push_fault(2'b10);
    start_miss(32'h0040_3ABC);
    pulse_after("super_bad", 1);

    // Timeout: four unacknowledged L1 cycles.
    mem[32'h0001_0004] = 32'h0002_0001;
    ack_en = 1'b0;
    push_fault(2'b11);
    start_miss(32'h0040_3ABC);
    for (int i = 0; i < 4; i++) begin
      check("to_req_held", mem_req, 1);
      @(negedge clk);
    end
    check("to_pulse", page_fault, 1);
    check("to_req_drop", mem_req, 0);
    ack_en = 1'b1;
    @(negedge clk);
    check("to_ready", miss_ready, 1);

    // Flush during L0 wait; request completes, then silent return to idle.
    slow_addr  = 32'h0002_000C;
    slow_delay = 3;
    start_miss(32'h0040_3ABC);
    @(negedge clk);
    flush = 1'b1;
    check("fl_l0_req", mem_req, 1);
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("fl_req_kept", mem_req, 1);
    @(negedge clk);
    check("fl_ready", miss_ready, 1);
    check("fl_req_gone", mem_req, 0);
    check("fl_no_pulse", {fill_valid, unfault, page_fault}, 0);

    // Ack on the timeout cycle wins; a miss while busy is ignored.
    push_fill(20'h00403, 20'h12345);
    start_miss(32'h0040_3ABC);
    @(negedge clk);
    miss_va    = 32'h0080_0000;
    miss_valid = 1'b1;
    @(negedge clk);
    miss_valid = 1'b0;
    wait_pulse("ackwin", 10);
    @(negedge clk);
    check("no_phantom_walk", {miss_ready, mem_req}, 2'b10);

    // Flush while idle has no effect; non-leaf L0 PTE is a bad leaf.
    slow_addr = 32'hFFFF_FFFF;
    mem[32'h0002_000C] = 32'h1234_5001;
    push_fault(2'b10);
    flush = 1'b1;
    start_miss(32'h0040_3ABC);
    flush = 1'b0;
    pulse_after("l0_nonleaf", 2);

    // Invalid level-0 PTE.
    mem[32'h0002_000C] = 32'h1234_5000;
    push_fault(2'b01);
    start_miss(32'h0040_3ABC);
    pulse_after("inv_l0", 2);

    // Asynchronous reset while L0 request outstanding.
    mem[32'h0002_000C] = 32'h1234_5003;
    slow_addr = 32'h0002_000C;
    start_miss(32'h0040_3ABC);
    @(negedge clk);
    check("rst_l0_req", mem_req, 1);
    #2 rst = 1'b0;
    #1 check_reset("async_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Normal walk after reset recovery.
    slow_addr = 32'hFFFF_FFFF;
    push_fill(20'h00403, 20'h12345);
    start_miss(32'h0040_3ABC);
    wait_pulse("post_reset", 10);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
